// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: RV32 load/store width codes and FSM states.
package dmem_pkg;

  localparam int MEM_BYTES_DEF = 128;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Control fields captured at the accept handshake.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic       dbg;
  } req_ctl_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: width/sign + low address bits -> byte enables, replicated
// store data, extended load data and misalign/illegal flags.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] rsh;

  assign rsh = rdata >> {off, 3'b000};

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_H: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{rsh[15]}}, rsh[15:0]};
        misalign  = off[0];
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = |off;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'b0, rsh[7:0]};
        illegal   = we;
      end
      F3_HU: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'b0, rsh[15:0]};
        misalign  = off[0];
        illegal   = we;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin arbiter between CPU and debug ports feeding
// a single-outstanding IDLE->ISSUE->WAIT->RESP sequencer with fixed 3-cycle latency.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = dmem_pkg::MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [2:0]        cpu_req_funct3,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  output logic              cpu_rsp_fault,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [31:0]       dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [31:0]       dbg_rsp_rdata,
  output logic              dbg_rsp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              last_dbg_q;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_fault_q;

  logic              idle, grant_cpu, grant_dbg, accept;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, rdata_ext;
  logic              misalign, illegal, range_err, fault;

  // Contention goes to whichever port did not win last; last_dbg_q=1 out of reset so cpu wins first.
  assign idle          = (state_q == ST_IDLE) && !reset;
  assign grant_cpu     = cpu_req_valid && (!dbg_req_valid || last_dbg_q);
  assign grant_dbg     = dbg_req_valid && (!cpu_req_valid || !last_dbg_q);
  assign cpu_req_ready = idle && grant_cpu;
  assign dbg_req_ready = idle && grant_dbg;
  assign accept        = cpu_req_ready || dbg_req_ready;

  dmem_lane_fmt u_fmt (
    .funct3    (ctl_q.funct3),
    .we        (ctl_q.we),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  assign range_err = addr_q >= ADDR_W'(MEM_BYTES);
  assign fault     = misalign || illegal || range_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_dbg_q  <= 1'b1;
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctl_q.we     <= dbg_req_ready ? dbg_req_we : cpu_req_we;
        ctl_q.funct3 <= dbg_req_ready ? F3_W : cpu_req_funct3;
        ctl_q.dbg    <= dbg_req_ready;
        addr_q       <= dbg_req_ready ? dbg_req_addr : cpu_req_addr;
        wdata_q      <= dbg_req_ready ? dbg_req_wdata : cpu_req_wdata;
        last_dbg_q   <= dbg_req_ready;
      end
      // mem_rdata carries the ISSUE-cycle read during WAIT.
      if (state_q == ST_WAIT) begin
        rsp_rdata_q <= (!ctl_q.we && !fault) ? rdata_ext : 32'h0;
        rsp_fault_q <= fault;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (!fault) begin
          mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
          mem_we    = ctl_q.we;
          mem_re    = !ctl_q.we;
          mem_be    = be;
          mem_wdata = ctl_q.we ? wdata_rep : 32'h0;
        end
      end
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cpu_rsp_valid = (state_q == ST_RESP) && !ctl_q.dbg;
  assign dbg_rsp_valid = (state_q == ST_RESP) &&  ctl_q.dbg;
  assign cpu_rsp_rdata = cpu_rsp_valid ? rsp_rdata_q : 32'h0;
  assign dbg_rsp_rdata = dbg_rsp_valid ? rsp_rdata_q : 32'h0;
  assign cpu_rsp_fault = cpu_rsp_valid && rsp_fault_q;
  assign dbg_rsp_fault = dbg_rsp_valid && rsp_fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, arbitration and reset sequences,
// then random traffic against a byte-array reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [2:0]  cpu_req_funct3;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_rsp_valid, cpu_rsp_fault;
  logic [31:0] cpu_rsp_rdata;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_we;
  logic [31:0] dbg_req_addr, dbg_req_wdata;
  logic        dbg_rsp_valid, dbg_rsp_fault;
  logic [31:0] dbg_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_BYTES(128), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_funct3(cpu_req_funct3), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_fault(cpu_rsp_fault),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_fault(dbg_rsp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: 1-cycle registered read, byte-enable write.
  logic [7:0] tbmem [0:127] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_re && mem_addr < 128)
      mem_rdata <= {tbmem[mem_addr[6:0] + 7'd3], tbmem[mem_addr[6:0] + 7'd2],
                    tbmem[mem_addr[6:0] + 7'd1], tbmem[mem_addr[6:0]]};
    if (mem_we && mem_addr < 128)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) tbmem[mem_addr[6:0] + 7'(i)] <= mem_wdata[8*i +: 8];
  end

  // Reference: byte array, access rules stated as size/sign/alignment arithmetic.
  logic [7:0] ref_mem [0:127] = '{default: 8'h00};

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output bit f,
                                output logic [3:0] be, output logic [31:0] wrep);
    int size; bit sgn; bit legal;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    f = !legal || (addr % size != 0) || (addr >= 128);
    rd = 0; be = 0; wrep = 0;
    if (!f) begin
      be   = 4'(((1 << size) - 1) << (addr % 4));
      wrep = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      for (int i = 0; i < size; i++) begin
        if (we) ref_mem[addr + i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[addr + i];
      end
      if (!we && sgn && rd[8*size-1]) rd = rd | ~((32'h1 << (8*size)) - 1);
    end
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_funct3 = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
    dbg_req_valid = 0; dbg_req_we = 0; dbg_req_addr = 0; dbg_req_wdata = 0;
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_ctl"}, {24'b0, cpu_req_ready, dbg_req_ready, cpu_rsp_valid, dbg_rsp_valid,
                      cpu_rsp_fault, dbg_rsp_fault, mem_we, mem_re}, 32'h0);
    chk({n, "_data"}, cpu_rsp_rdata | dbg_rsp_rdata | mem_addr | mem_wdata | {28'b0, mem_be}, 32'h0);
  endtask

  // One access through port dbg/cpu; checks ISSUE signals and the T+3 response.
  task automatic access(input bit dbg, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] e_rd, input bit e_f,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input string tag);
    int w; int nre; int nwe; logic [3:0] be_s; logic [31:0] wd_s; logic [31:0] ad_s; bit early;
    w = 0; nre = 0; nwe = 0; early = 0;
    @(negedge clk);
    if (dbg) begin dbg_req_valid = 1; dbg_req_we = we; dbg_req_addr = addr; dbg_req_wdata = wd; end
    else begin cpu_req_valid = 1; cpu_req_we = we; cpu_req_funct3 = f3; cpu_req_addr = addr; cpu_req_wdata = wd; end
    #1;
    while (!(dbg ? dbg_req_ready : cpu_req_ready) && w < 20) begin @(negedge clk); #1; w++; end
    chk({tag, "_ready"}, 32'(w < 20), 32'h1);
    if (w >= 20) begin idle_inputs(); return; end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    be_s = mem_be; wd_s = mem_wdata; ad_s = mem_addr;
    nre += int'(mem_re); nwe += int'(mem_we);
    early |= cpu_rsp_valid | dbg_rsp_valid;
    @(negedge clk);
    nre += int'(mem_re); nwe += int'(mem_we);
    early |= cpu_rsp_valid | dbg_rsp_valid;
    @(negedge clk);
    nre += int'(mem_re); nwe += int'(mem_we);
    chk({tag, "_re_cnt"}, 32'(nre), 32'(!we && !e_f));
    chk({tag, "_we_cnt"}, 32'(nwe), 32'(we && !e_f));
    chk({tag, "_be"}, {28'b0, be_s}, {28'b0, e_be});
    if (!e_f) chk({tag, "_addr"}, ad_s, addr & ~32'h3);
    if (we && !e_f) chk({tag, "_wdata"}, wd_s, e_wd);
    chk({tag, "_early_rsp"}, 32'(early), 32'h0);
    chk({tag, "_rsp_valid"}, {30'b0, cpu_rsp_valid, dbg_rsp_valid}, dbg ? 32'h1 : 32'h2);
    chk({tag, "_rdata"}, dbg ? dbg_rsp_rdata : cpu_rsp_rdata, e_rd);
    chk({tag, "_fault"}, 32'(dbg ? dbg_rsp_fault : cpu_rsp_fault), 32'(e_f));
  endtask

  typedef struct {
    bit dbg; bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    logic [31:0] e_rd; bit e_f; logic [3:0] e_be; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] m_rd, m_wr; bit m_f; logic [3:0] m_be;
    int gport[$]; int gcyc[$]; int rport[$]; int rcyc[$]; logic [31:0] rdat[$];
    int w; bit seen;

    tbl[0]  = '{0, 1, 3'b010, 32'h10, 32'h12345678, 32'h0,        0, 4'hF, 32'h12345678};
    tbl[1]  = '{0, 0, 3'b010, 32'h10, 32'h0,        32'h12345678, 0, 4'hF, 32'h0};
    tbl[2]  = '{0, 1, 3'b000, 32'h21, 32'h000000AB, 32'h0,        0, 4'h2, 32'hABABABAB};
    tbl[3]  = '{0, 0, 3'b000, 32'h21, 32'h0,        32'hFFFFFFAB, 0, 4'h2, 32'h0};
    tbl[4]  = '{0, 0, 3'b100, 32'h21, 32'h0,        32'h000000AB, 0, 4'h2, 32'h0};
    tbl[5]  = '{0, 1, 3'b001, 32'h22, 32'h00008001, 32'h0,        0, 4'hC, 32'h80018001};
    tbl[6]  = '{0, 0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 0, 4'hC, 32'h0};
    tbl[7]  = '{0, 0, 3'b101, 32'h22, 32'h0,        32'h00008001, 0, 4'hC, 32'h0};
    tbl[8]  = '{0, 0, 3'b001, 32'h23, 32'h0,        32'h0,        1, 4'h0, 32'h0};
    tbl[9]  = '{0, 0, 3'b010, 32'h80, 32'h0,        32'h0,        1, 4'h0, 32'h0};
    tbl[10] = '{0, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 4'h0, 32'h0};
    tbl[11] = '{1, 1, 3'b010, 32'h7C, 32'hCAFEF00D, 32'h0,        0, 4'hF, 32'hCAFEF00D};
    tbl[12] = '{1, 0, 3'b010, 32'h7C, 32'h0,        32'hCAFEF00D, 0, 4'hF, 32'h0};
    tbl[13] = '{0, 1, 3'b100, 32'h30, 32'h00000055, 32'h0,        1, 4'h0, 32'h0};
    tbl[14] = '{0, 0, 3'b010, 32'h20, 32'h0,        32'h8001AB00, 0, 4'hF, 32'h0};

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    #1 chk_all_zero("reset_state");

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_rd, m_f, m_be, m_wr);
      access(tbl[i].dbg, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
             tbl[i].e_rd, tbl[i].e_f, tbl[i].e_be, tbl[i].e_wd, $sformatf("vec%0d", i));
    end

    // Both ports valid continuously after reset: grants alternate cpu,dbg,...
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_funct3 = 3'b010; cpu_req_addr = 32'h10;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 32'h7C;
    for (int c = 0; c < 40 && rport.size() < 4; c++) begin
      #1;
      chk("arb_onehot", 32'(cpu_req_ready & dbg_req_ready), 32'h0);
      if (cpu_req_ready) begin gport.push_back(0); gcyc.push_back(c); end
      if (dbg_req_ready) begin gport.push_back(1); gcyc.push_back(c); end
      if (cpu_rsp_valid) begin rport.push_back(0); rcyc.push_back(c); rdat.push_back(cpu_rsp_rdata); end
      if (dbg_rsp_valid) begin rport.push_back(1); rcyc.push_back(c); rdat.push_back(dbg_rsp_rdata); end
      @(posedge clk); #1;
      if (gport.size() >= 4) idle_inputs();
      @(negedge clk);
    end
    idle_inputs();
    chk("arb_ngrant", 32'(gport.size()), 32'd4);
    chk("arb_nrsp", 32'(rport.size()), 32'd4);
    for (int i = 0; i < gport.size() && i < 4; i++) begin
      chk($sformatf("arb_grant%0d", i), 32'(gport[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("arb_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd4);
    end
    for (int i = 0; i < rport.size() && i < gport.size() && i < 4; i++) begin
      chk($sformatf("arb_rsp_port%0d", i), 32'(rport[i]), 32'(gport[i]));
      chk($sformatf("arb_rsp_lat%0d", i), 32'(rcyc[i] - gcyc[i]), 32'd3);
      chk($sformatf("arb_rsp_data%0d", i), rdat[i], rport[i] ? 32'hCAFEF00D : 32'h12345678);
    end

    // Reset during WAIT of a cpu load: response dropped, cpu wins next contention.
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_funct3 = 3'b010; cpu_req_addr = 32'h10;
    w = 0; #1;
    while (!cpu_req_ready && w < 20) begin @(negedge clk); #1; w++; end
    chk("rst_ready", 32'(w < 20), 32'h1);
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1 reset = 1;
    @(posedge clk);
    @(negedge clk); chk_all_zero("rst_mid");
    reset = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= cpu_rsp_valid | dbg_rsp_valid; end
    chk("rst_no_rsp", 32'(seen), 32'h0);
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_funct3 = 3'b010; cpu_req_addr = 32'h10;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 32'h7C;
    #1 chk("rst_grant", {30'b0, cpu_req_ready, dbg_req_ready}, 32'h2);
    @(posedge clk); #1 idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {30'b0, cpu_rsp_valid, dbg_rsp_valid}, 32'h2);
    chk("rst_rsp_data", cpu_rsp_rdata, 32'h12345678);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      bit d; bit we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
      d  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      f3 = d ? 3'b010 : 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 143));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      wd = $urandom;
      model(we, f3, a, wd, m_rd, m_f, m_be, m_wr);
      access(d, we, f3, a, wd, m_rd, m_f, m_be, m_wr, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
